// File: rtl/baw_input_frontend.sv
// baw_input_frontend: button sync/debounce/press pulses and card switch qualification.
// Define BAW_BTN_LOCKOUT_EN to suppress pulses from a button pressed while another is held.
module baw_input_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    input  logic [8:0] sw_raw,
    input  logic [8:0] avail,
    input  logic       sel_en,
    output logic [4:0] press_pulse,
    output logic [4:0] btn_level,
    output logic       card_valid,
    output logic [3:0] card_idx,
    output logic [8:0] card_onehot,
    output logic       sel_error
);
    localparam logic [CNT_W-1:0] BTN_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0] btn_s1, btn_s2, lvl_d, pulse_next;
    logic [8:0] sw_s1, sw_s2, sw_prev;
    logic [CNT_W-1:0] cnt [5];
    logic [CNT_W-1:0] sw_cnt;
    logic stable, one_hot, valid_next, error_next;
    logic [3:0] idx_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1 <= '0;
            sw_s2 <= '0;
            sw_prev <= '0;
            lvl_d <= '0;
            btn_level <= '0;
            sw_cnt <= '0;
            stable <= 1'b0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1 <= sw_raw;
            sw_s2 <= sw_s1;
            sw_prev <= sw_s2;
            lvl_d <= btn_level;
            for (int i = 0; i < 5; i++) begin
                if (btn_s2[i] == btn_level[i]) cnt[i] <= '0;
                else if (cnt[i] == BTN_LAST) begin
                    btn_level[i] <= ~btn_level[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + CNT_W'(1);
            end
            // any change restarts the whole-vector stability window
            if (sw_s2 != sw_prev) begin
                sw_cnt <= '0;
                stable <= 1'b0;
            end else if (!stable) begin
                if (sw_cnt == SW_LAST) begin
                    stable <= 1'b1;
                    sw_cnt <= '0;
                end else sw_cnt <= sw_cnt + CNT_W'(1);
            end
        end
    end

`ifdef BAW_BTN_LOCKOUT_EN
    logic [4:0] other_held;
    always_comb begin
        other_held = '0;
        for (int i = 0; i < 5; i++) other_held[i] = |(lvl_d & ~(5'd1 << i));
        pulse_next = btn_level & ~lvl_d & ~other_held;
    end
`else
    assign pulse_next = btn_level & ~lvl_d;
`endif

    always_comb begin
        one_hot = (sw_prev != 9'd0) && ((sw_prev & (sw_prev - 9'd1)) == 9'd0);
        valid_next = sel_en && stable && one_hot && |(sw_prev & avail);
        error_next = sel_en && stable && (sw_prev != 9'd0) && !valid_next;
        idx_next = 4'd15;
        for (int i = 0; i < 9; i++) if (valid_next && sw_prev[i]) idx_next = 4'(i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_pulse <= '0;
            card_valid <= 1'b0;
            card_idx <= 4'd15;
            card_onehot <= '0;
            sel_error <= 1'b0;
        end else begin
            press_pulse <= pulse_next;
            card_valid <= valid_next;
            card_idx <= idx_next;
            card_onehot <= valid_next ? sw_prev : 9'd0;
            sel_error <= error_next;
        end
    end
endmodule
